// File: rtl/crot_if.sv
// Handshake bundle for the controlled-rotation unit: an input beat channel and a rotated output channel.
interface crot_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned KW = 3
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_r;
    logic signed [W-1:0] in_i;
    logic [KW-1:0]       k;
    logic                ctrl;
    logic                inv;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_r;
    logic signed [W-1:0] out_i;
    logic                out_sat;

    modport master (
        output in_valid, in_r, in_i, k, ctrl, inv, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_sat
    );

    modport slave (
        input  in_valid, in_r, in_i, k, ctrl, inv, out_ready,
        output in_ready, out_valid, out_r, out_i, out_sat
    );
endinterface

// File: rtl/crot_unit.sv
// Controlled phase rotation by 2*pi/2^k on a fixed-point complex amplitude.
// Three-stage pipeline (operands, products, round/saturate) with a global stall enable.
module crot_unit #(
    parameter int unsigned W    = 8,
    parameter int unsigned FRAC = 4,
    parameter int unsigned KW   = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    crot_if.slave   bus
);
    localparam int unsigned KN = 1 << KW;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = 2 * W + 1;
    localparam real         PI = 3.14159265358979323846;

    localparam logic signed [SW-1:0] HALF = SW'(1 << (FRAC - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (W - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    // Rounded cos/sin of 2*pi/2^k, fixed at elaboration.
    logic signed [W-1:0] cos_tab [KN];
    logic signed [W-1:0] sin_tab [KN];

    for (genvar g = 0; g < KN; g++) begin : g_tab
        localparam real ANG = 2.0 * PI / real'(1 << g);
        localparam int  CV  = $rtoi($floor($cos(ANG) * real'(1 << FRAC) + 0.5));
        localparam int  SV  = $rtoi($floor($sin(ANG) * real'(1 << FRAC) + 0.5));
        assign cos_tab[g] = W'(CV);
        assign sin_tab[g] = W'(SV);
    end

    logic en;
    assign en           = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = en;

    logic                s1_v, s1_ctrl;
    logic signed [W-1:0] s1_r, s1_i, s1_c, s1_s;

    logic                s2_v, s2_ctrl;
    logic signed [W-1:0] s2_r, s2_i;
    logic signed [PW-1:0] s2_rc, s2_is, s2_rs, s2_ic;

    // S1: operands and table lookup; inverse rotation flips the sine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_ctrl <= 1'b0;
            s1_r    <= '0;
            s1_i    <= '0;
            s1_c    <= '0;
            s1_s    <= '0;
        end else if (en) begin
            s1_v    <= bus.in_valid;
            s1_ctrl <= bus.ctrl;
            s1_r    <= bus.in_r;
            s1_i    <= bus.in_i;
            s1_c    <= cos_tab[bus.k];
            s1_s    <= bus.inv ? -sin_tab[bus.k] : sin_tab[bus.k];
        end
    end

    // S2: full-precision products; raw operands ride along for pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_ctrl <= 1'b0;
            s2_r    <= '0;
            s2_i    <= '0;
            s2_rc   <= '0;
            s2_is   <= '0;
            s2_rs   <= '0;
            s2_ic   <= '0;
        end else if (en) begin
            s2_v    <= s1_v;
            s2_ctrl <= s1_ctrl;
            s2_r    <= s1_r;
            s2_i    <= s1_i;
            s2_rc   <= PW'(s1_r) * PW'(s1_c);
            s2_is   <= PW'(s1_i) * PW'(s1_s);
            s2_rs   <= PW'(s1_r) * PW'(s1_s);
            s2_ic   <= PW'(s1_i) * PW'(s1_c);
        end
    end

    logic signed [SW-1:0] re_full, im_full, re_sh, im_sh;
    logic signed [W-1:0]  nxt_r, nxt_i;
    logic                 nxt_sat;

    // S3 combine: round half up, then clamp to the W-bit signed range.
    always_comb begin
        nxt_r   = s2_r;
        nxt_i   = s2_i;
        nxt_sat = 1'b0;
        re_full = SW'(s2_rc) - SW'(s2_is) + HALF;
        im_full = SW'(s2_rs) + SW'(s2_ic) + HALF;
        re_sh   = re_full >>> FRAC;
        im_sh   = im_full >>> FRAC;
        if (s2_ctrl) begin
            if (re_sh > MAXV) begin
                nxt_r   = W'(MAXV);
                nxt_sat = 1'b1;
            end else if (re_sh < MINV) begin
                nxt_r   = W'(MINV);
                nxt_sat = 1'b1;
            end else begin
                nxt_r   = W'(re_sh);
            end
            if (im_sh > MAXV) begin
                nxt_i   = W'(MAXV);
                nxt_sat = 1'b1;
            end else if (im_sh < MINV) begin
                nxt_i   = W'(MINV);
                nxt_sat = 1'b1;
            end else begin
                nxt_i   = W'(im_sh);
            end
        end
    end

    // S3 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
            bus.out_sat   <= 1'b0;
        end else if (en) begin
            bus.out_valid <= s2_v;
            bus.out_r     <= nxt_r;
            bus.out_i     <= nxt_i;
            bus.out_sat   <= nxt_sat;
        end
    end
endmodule

// File: doc/crot_unit.md
CROT_UNIT -- requirements
Module: crot_unit

Interface
REQ-001 Parameter W, default 8: total signed two's-complement width of each amplitude component.
REQ-002 Parameter FRAC, default 4: fractional bits. Legal configurations satisfy W-FRAC >= 2 and FRAC >= 1.
REQ-003 Parameter KW, default 3: width of rotation index k; KMAX = 2^KW-1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  input beat present.
REQ-007 in_ready  out  1  unit accepts the beat this cycle.
REQ-008 in_r, in_i  in  W  signed input amplitude (real, imaginary).
REQ-009 k  in  KW  rotation index; angle = 2*pi/2^k.
REQ-010 ctrl  in  1  control qubit; 1 = rotate, 0 = pass through unchanged.
REQ-011 inv  in  1  1 = inverse rotation (angle negated).
REQ-012 out_valid  out  1  output beat present.
REQ-013 out_ready  in  1  downstream accepts the beat.
REQ-014 out_r, out_i  out  W  signed rotated amplitude.
REQ-015 out_sat  out  1  this beat was clamped in either component.

Function
REQ-016 A transfer occurs on a clock edge where valid and ready are both 1; otherwise no transfer occurs.
REQ-017 The cos/sin table holds KMAX+1 entries of elaboration-time constants: round(cos(2*pi/2^k)*2^FRAC) and round(sin(2*pi/2^k)*2^FRAC), each W bits.
REQ-018 The datapath is a 3-stage pipeline.
- S1 registers the inputs, the table outputs, ctrl, and inv.
- When inv=1, S1 negates the sin value.
REQ-019 S2 registers four full-precision 2W-bit products: ar*c, ai*s, ar*s, ai*c.
REQ-020 S3 computes re = ar*c - ai*s and im = ar*s + ai*c at 2W+1 bits.
- Each result gets 2^(FRAC-1) added, then an arithmetic shift right by FRAC (round half up).
- Each result then saturates to [-2^(W-1), 2^(W-1)-1].
- The saturated results are registered to out_r and out_i.
REQ-021 out_sat=1 when either component clamped in REQ-020.
REQ-022 When ctrl=0, out_r=in_r, out_i=in_i and out_sat=0, bit-exact with no rounding, at the same latency.
REQ-023 Latency is exactly 3 cycles from an input transfer to out_valid, provided there are no stalls.
REQ-024 Each stage carries a valid bit. Pipeline advance enable is en = out_ready OR NOT out_valid.
- in_ready = en.
- All stages hold their contents when en=0.
REQ-025 When the pipeline is never stalled, throughput is one beat per cycle.
REQ-026 When out_valid=1 and out_ready=0, out_r, out_i, and out_sat remain stable until the transfer completes.
REQ-027 Beats leave in acceptance order; none is lost or duplicated.
REQ-028 Bubbles (in_valid=0 while en=1) propagate as invalid stage slots and are never emitted.

Reset
REQ-029 While rst_n=0, every stage valid bit and all data registers are 0.
- out_valid=0, out_r=0, out_i=0, out_sat=0, in_ready=1.
REQ-030 Reset asserted mid-operation discards all in-flight beats immediately and asynchronously.
REQ-031 The first transfer is possible on the first rising edge after rst_n deasserts.

Verification (W=8, FRAC=4, KW=3)
REQ-032 k=2, ctrl=1, inv=0, in=(16,0) -> 3 cycles later out=(0,16), out_sat=0.
REQ-033 k=2, ctrl=1, inv=1, in=(16,0) -> out=(0,-16); k=1, ctrl=1, in=(16,0) -> out=(-16,0).
REQ-034 k=3 (table 11,11), ctrl=1, in=(112,112) -> out=(0,127), out_sat=1; in=(-128,-128), ctrl=0 -> out=(-128,-128), out_sat=0.
REQ-035 Back-to-back stream of 8 beats with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
REQ-036 Stall test:
- Stimulus: out_ready=0 once out_valid=1, held 5 cycles, then out_ready=1.
- Response: in_ready=0 throughout the stall; outputs hold unchanged; no beat is lost or duplicated.
REQ-037 Reset test:
- Stimulus: rst_n pulsed low with 3 beats in flight.
- Response: out_valid=0 at once; no stale beat appears after release.
